env_sweep_scheduler: RTL and testbench
======================================

// Module: env_sweep_scheduler
// PURPOSE
// - Sequences the environment grid update once per game tick: walks every cell in raster order and reads its 8 neighbours plus itself through the environment lookup port.
// - Presents the gathered neighbourhood to nextSignal/nextSugar and the ants, then issues exactly one write per cell.
// - Replaces free-running writeLoc/viewLoc sweeping and the hold_locs handshake with a single deterministic scheduler.
// PARAMETERS
// - X_BITS       8    grid column address width
// - Y_BITS       7    grid row address width
// - X_MAX        159  last column index (grid is 160 wide)
// - Y_MAX        119  last row index (grid is 120 tall)
// - SIGNAL_BITS  4    pheromone signal width
// - RD_LAT       1    environment lookup read latency in cycles, 1..3
// PORTS
// - clk                  in   1              system clock (CLOCK_50 domain)
// - RESET_SIM_N          in   1              asynchronous, active-low reset
// - tick                 in   1              1-cycle game-tick pulse, synchronous to clk
// - run                  in   1              high = simulation running (~SETUP_MODE)
// - pause                in   1              high = freeze at the next cell boundary
// - lookup_x             out  X_BITS         read address, column
// - lookup_y             out  Y_BITS         read address, row
// - lookup_rd            out  1              read strobe
// - lookup_sugar         in   1              read data, sugar; valid RD_LAT cycles after lookup_rd
// - lookup_signal        in   SIGNAL_BITS    read data, signal; valid RD_LAT cycles after lookup_rd
// - surrounding_signals  out  8*SIGNAL_BITS  neighbour signals, index 0..7 = N,NE,E,SE,S,SW,W,NW
// - cur_sugar            out  1              centre-cell sugar
// - cur_signal           out  SIGNAL_BITS    centre-cell signal
// - write_x              out  X_BITS         cell currently being updated, column
// - write_y              out  Y_BITS         cell currently being updated, row
// - write_flag           out  1              1-cycle environment write strobe
// - busy                 out  1              high while a sweep is in progress
// - sweep_done           out  1              1-cycle pulse after the write to (X_MAX,Y_MAX)
// - overrun              out  1              sticky; a tick arrived while a tick was already pending
// BEHAVIOUR
// - Reset: all outputs 0. State = IDLE, cell = (0,0), pending = 0, overrun = 0.
// - States:
//   - IDLE: on (tick & run) go to READ. If tick arrives while busy, set pending; if pending is already 1, set overrun.
//   - READ: 9 cycles, k = 0..8, one per cycle.
//     - k = 0..7 reads neighbour k; k = 8 reads the centre.
//     - lookup_rd = 1 only when the target is on-grid. No wrap-around.
//   - DRAIN: RD_LAT cycles.
//   - WRITE: 1 cycle, write_flag = 1.
//   - NEXT: advance the cell; return to READ, or to IDLE after the last cell.
// - Read data is captured RD_LAT cycles after each read slot. Off-grid slots capture 0 for signal and sugar.
//   - Example: cell (0,0) gets N, NE, SW, W, NW = 0.
// - Outputs during WRITE:
//   - surrounding_signals, cur_* and write_x/y are stable for the whole WRITE cycle.
//   - write_x/y are held from READ entry until NEXT.
// - Latency: cell period = 10 + RD_LAT cycles. Full sweep = (X_MAX+1)*(Y_MAX+1)*(10+RD_LAT) cycles.
// - Advance: x increments; at X_MAX it wraps to 0 and y increments. After the write to (X_MAX,Y_MAX):
//   - pulse sweep_done, go to IDLE, cell = (0,0).
//   - If pending = 1, clear it and start the next sweep on the following cycle.
// - pause or ~run mid-cell: the current cell completes, including its write. The FSM then holds in NEXT with busy = 1 and no strobes.
//   - It resumes at the next cell when pause = 0 and run = 1.
//   - A cell is never written twice and never skipped.
// - tick and the sweep_done cycle together: the tick counts as pending, so the next sweep starts immediately.
// - Reset asserted mid-sweep: immediate return to reset state. No partial write; write_flag drops asynchronously.
// - Width rules: neighbour coordinates are computed with 1 extra bit (signed) for the bounds check, then truncated for lookup_x/y.
// STRUCTURE
// - sim_pkg (shared):
//   - X_BITS/Y_BITS/SIGNAL_BITS constants
//   - sweep_state_t enum {IDLE, READ, DRAIN, WRITE, NEXT}
//   - neighbour offset table DX/DY[0:8]
// - Sub-module nbr_addr_gen (combinational): (cell_x, cell_y, k) -> (lookup_x, lookup_y, on_grid).
// - Top: FSM, cell counters, RD_LAT-deep shift register of {k, on_grid} that steers capture, pending/overrun flags.
// TESTING
// - Test grid: X_MAX=3, Y_MAX=2, RD_LAT=1. Environment model returns signal = 4*y + x, sugar = x==y.
// 1. Reset, run=1, one tick -> 12 write_flag pulses at write_(x,y) = (0,0),(1,0)..(3,2), 11 cycles apart; one sweep_done after (3,2); busy=0 afterwards.
// 2. Cell (1,1) WRITE cycle -> surrounding_signals = {N=1,NE=2,E=6,SE=10,S=9,SW=8,W=4,NW=0}; cur_signal=5; cur_sugar=1.
// 3. Cell (0,0) -> lookup_rd low in the N, NE, SW, W, NW slots; those entries = 0; E=1, SE=5, S=4.
// 4. pause=1 during READ of (2,0) -> the (2,0) write occurs, then no strobes for 20 cycles; pause=0 -> next write is at (3,0).
// 5. Two ticks during one sweep -> overrun=1; exactly one further sweep follows sweep_done.
// 6. RESET_SIM_N low at the DRAIN of (1,2) -> write_flag never asserted for (1,2); all outputs 0; next tick restarts at (0,0).

Source files
------------

// File: rtl/env_sweep_scheduler_pkg.sv
// env_sweep_scheduler_pkg: shared widths, sweep FSM states and neighbour offset table
package env_sweep_scheduler_pkg;
  localparam int SWEEP_X_BITS = 8;
  localparam int SWEEP_Y_BITS = 7;
  localparam int SWEEP_SIGNAL_BITS = 4;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, NEXT} sweep_state_t;
  // slot order N,NE,E,SE,S,SW,W,NW,centre; north is y-1
  localparam logic signed [1:0] DX [9] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1, -2'sd1, -2'sd1, 2'sd0};
  localparam logic signed [1:0] DY [9] = '{-2'sd1, -2'sd1, 2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1, 2'sd0};
endpackage

// File: rtl/env_sweep_scheduler_nbr_addr_gen.sv
// nbr_addr_gen: neighbour address and on-grid flag for slot k of a cell
// Ports: cell_x_i/cell_y_i cell, k_i slot 0..8 -> lookup_x_o/lookup_y_o address, on_grid_o bounds result
module nbr_addr_gen import env_sweep_scheduler_pkg::*; #(
  parameter int X_BITS = SWEEP_X_BITS,
  parameter int Y_BITS = SWEEP_Y_BITS,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic [X_BITS-1:0] cell_x_i,
  input  logic [Y_BITS-1:0] cell_y_i,
  input  logic [3:0]        k_i,
  output logic [X_BITS-1:0] lookup_x_o,
  output logic [Y_BITS-1:0] lookup_y_o,
  output logic              on_grid_o
);
  localparam logic signed [X_BITS:0] XM = (X_BITS+1)'(X_MAX);
  localparam logic signed [Y_BITS:0] YM = (Y_BITS+1)'(Y_MAX);
  logic [3:0] ks;
  logic signed [X_BITS:0] nx;
  logic signed [Y_BITS:0] ny;
  assign ks = k_i > 4'd8 ? 4'd8 : k_i;
  // one extra signed bit so -1 and MAX+1 are both detectable
  assign nx = $signed({1'b0, cell_x_i}) + (X_BITS+1)'(DX[ks]);
  assign ny = $signed({1'b0, cell_y_i}) + (Y_BITS+1)'(DY[ks]);
  assign on_grid_o = !nx[X_BITS] && nx <= XM && !ny[Y_BITS] && ny <= YM;
  assign lookup_x_o = nx[X_BITS-1:0];
  assign lookup_y_o = ny[Y_BITS-1:0];
endmodule

// File: rtl/env_sweep_scheduler.sv
// env_sweep_scheduler: per-tick raster sweep reading each cell's 3x3 neighbourhood, then one write per cell
// Ports: clk, RESET_SIM_N async low reset; tick/run/pause control; lookup_* read port (RD_LAT latency);
//        surrounding_signals/cur_* gathered neighbourhood; write_x/y/write_flag write port;
//        busy, sweep_done pulse, sticky overrun
module env_sweep_scheduler import env_sweep_scheduler_pkg::*; #(
  parameter int X_BITS = SWEEP_X_BITS,
  parameter int Y_BITS = SWEEP_Y_BITS,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int SIGNAL_BITS = SWEEP_SIGNAL_BITS,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     RESET_SIM_N,
  input  logic                     tick,
  input  logic                     run,
  input  logic                     pause,
  output logic [X_BITS-1:0]        lookup_x,
  output logic [Y_BITS-1:0]        lookup_y,
  output logic                     lookup_rd,
  input  logic                     lookup_sugar,
  input  logic [SIGNAL_BITS-1:0]   lookup_signal,
  output logic [8*SIGNAL_BITS-1:0] surrounding_signals,
  output logic                     cur_sugar,
  output logic [SIGNAL_BITS-1:0]   cur_signal,
  output logic [X_BITS-1:0]        write_x,
  output logic [Y_BITS-1:0]        write_y,
  output logic                     write_flag,
  output logic                     busy,
  output logic                     sweep_done,
  output logic                     overrun
);
  sweep_state_t state_q;
  logic [X_BITS-1:0] cx_q, nx;
  logic [Y_BITS-1:0] cy_q, ny;
  logic [3:0] k_q;
  logic pend_q, overrun_q, done_q, on, rd, last_x, last_y;
  // each entry {valid, on_grid, k}; the oldest entry steers where returning data lands
  logic [RD_LAT-1:0][5:0] pipe_q;
  logic [5:0] tail;
  logic [7:0][SIGNAL_BITS-1:0] surr_q;
  logic [SIGNAL_BITS-1:0] cur_sig_q;
  logic cur_sug_q;
  nbr_addr_gen #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_nbr (
    .cell_x_i(cx_q), .cell_y_i(cy_q), .k_i(k_q), .lookup_x_o(nx), .lookup_y_o(ny), .on_grid_o(on)
  );
  assign rd = state_q == READ && on;
  assign lookup_rd = rd;
  assign lookup_x = rd ? nx : '0;
  assign lookup_y = rd ? ny : '0;
  assign tail = pipe_q[RD_LAT-1];
  assign last_x = cx_q == X_BITS'(X_MAX);
  assign last_y = cy_q == Y_BITS'(Y_MAX);
  assign surrounding_signals = surr_q;
  assign cur_signal = cur_sig_q;
  assign cur_sugar = cur_sug_q;
  assign write_x = cx_q;
  assign write_y = cy_q;
  assign write_flag = state_q == WRITE;
  assign busy = state_q != IDLE;
  assign sweep_done = done_q;
  assign overrun = overrun_q;
  always_ff @(posedge clk or negedge RESET_SIM_N)
    if (!RESET_SIM_N) begin
      state_q <= IDLE;
      cx_q <= '0;
      cy_q <= '0;
      k_q <= '0;
      pend_q <= 1'b0;
      overrun_q <= 1'b0;
      done_q <= 1'b0;
      pipe_q <= '0;
      surr_q <= '0;
      cur_sig_q <= '0;
      cur_sug_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pipe_q[0] <= {state_q == READ, on, k_q};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      if (tail[5] && tail[3:0] == 4'd8) begin
        cur_sig_q <= tail[4] ? lookup_signal : '0;
        cur_sug_q <= tail[4] & lookup_sugar;
      end else if (tail[5])
        surr_q[tail[2:0]] <= tail[4] ? lookup_signal : '0;
      if (tick && state_q != IDLE) begin
        pend_q <= 1'b1;
        overrun_q <= overrun_q | pend_q;
      end
      case (state_q)
        IDLE: if (run && (tick || pend_q)) begin
          state_q <= READ;
          k_q <= '0;
          pend_q <= 1'b0;
        end
        READ: begin
          k_q <= k_q == 4'd8 ? 4'd0 : k_q + 4'd1;
          if (k_q == 4'd8) state_q <= DRAIN;
        end
        DRAIN: begin
          k_q <= k_q + 4'd1;
          if (k_q == 4'(RD_LAT-1)) state_q <= WRITE;
        end
        // advance during WRITE so the next cell's READ follows without a gap
        WRITE: begin
          k_q <= '0;
          cx_q <= last_x ? '0 : cx_q + 1'b1;
          cy_q <= last_x ? (last_y ? '0 : cy_q + 1'b1) : cy_q;
          if (last_x && last_y) begin
            state_q <= IDLE;
            done_q <= 1'b1;
          end else
            state_q <= (pause || !run) ? NEXT : READ;
        end
        NEXT: if (!pause && run) state_q <= READ;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_env_sweep_scheduler.sv
// tb_env_sweep_scheduler: directed self-checking bench on a 4x3 grid with RD_LAT=1
module tb_env_sweep_scheduler;
  logic clk = 0, RESET_SIM_N = 0, tick = 0, run = 1, pause = 0;
  logic [7:0] lookup_x, write_x;
  logic [6:0] lookup_y, write_y;
  logic lookup_rd, cur_sugar, write_flag, busy, sweep_done, overrun;
  logic lookup_sugar = 0;
  logic [3:0] lookup_signal = 0, cur_signal;
  logic [31:0] surrounding_signals;
  int cyc = 0, tests = 0, fails = 0, sdcount = 0;
  typedef struct { logic [7:0] x; logic [6:0] y; int cyc; logic [31:0] surr; logic [3:0] cs; logic cu; } wr_t;
  wr_t wq[$];
  typedef struct { logic rd; logic [7:0] x; logic [6:0] y; } slot_t;
  slot_t sv[9];

  env_sweep_scheduler #(.X_MAX(3), .Y_MAX(2), .RD_LAT(1)) dut (
    .clk(clk), .RESET_SIM_N(RESET_SIM_N), .tick(tick), .run(run), .pause(pause),
    .lookup_x(lookup_x), .lookup_y(lookup_y), .lookup_rd(lookup_rd),
    .lookup_sugar(lookup_sugar), .lookup_signal(lookup_signal),
    .surrounding_signals(surrounding_signals), .cur_sugar(cur_sugar), .cur_signal(cur_signal),
    .write_x(write_x), .write_y(write_y), .write_flag(write_flag), .busy(busy),
    .sweep_done(sweep_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // environment: one-cycle read latency, junk on the bus when not strobed
  always @(posedge clk)
    if (lookup_rd) begin
      lookup_signal <= 4'(4 * lookup_y + lookup_x);
      lookup_sugar <= lookup_x == 8'(lookup_y);
    end else begin
      lookup_signal <= 4'hF;
      lookup_sugar <= 1'b1;
    end

  always @(negedge clk) begin
    if (write_flag) wq.push_back('{write_x, write_y, cyc, surrounding_signals, cur_signal, cur_sugar});
    if (sweep_done) sdcount++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_rd"}, lookup_rd, 0);
    chk({p, "_lx"}, lookup_x, 0);
    chk({p, "_ly"}, lookup_y, 0);
    chk({p, "_surr"}, surrounding_signals, 0);
    chk({p, "_csug"}, cur_sugar, 0);
    chk({p, "_csig"}, cur_signal, 0);
    chk({p, "_wx"}, write_x, 0);
    chk({p, "_wy"}, write_y, 0);
    chk({p, "_wf"}, write_flag, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, sweep_done, 0);
    chk({p, "_ovr"}, overrun, 0);
  endtask

  task automatic pulse_tick(output int t);
    @(negedge clk);
    tick = 1;
    t = cyc;
    @(negedge clk);
    tick = 0;
  endtask

  task automatic wait_write(input int lim, output logic ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (write_flag) ok = 1;
    end
  endtask

  task automatic wait_done(input int lim, output logic ok, output int at);
    ok = 0;
    at = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (sweep_done) begin
        ok = 1;
        at = cyc;
      end
    end
  endtask

  function automatic logic [3:0] env_sig(int x, int y);
    return (x < 0 || x > 3 || y < 0 || y > 2) ? 4'd0 : 4'(4 * y + x);
  endfunction

  function automatic logic [31:0] exp_surr(int x, int y);
    int dxs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    logic [31:0] r = 0;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = env_sig(x + dxs[k], y + dys[k]);
    return r;
  endfunction

  initial begin
    int t0, sd_at, sd_at2, n;
    logic ok;
    sv[0] = '{1'b0, 8'd0, 7'd0};
    sv[1] = '{1'b0, 8'd0, 7'd0};
    sv[2] = '{1'b1, 8'd1, 7'd0};
    sv[3] = '{1'b1, 8'd1, 7'd1};
    sv[4] = '{1'b1, 8'd0, 7'd1};
    sv[5] = '{1'b0, 8'd0, 7'd0};
    sv[6] = '{1'b0, 8'd0, 7'd0};
    sv[7] = '{1'b0, 8'd0, 7'd0};
    sv[8] = '{1'b1, 8'd0, 7'd0};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    RESET_SIM_N = 1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // full sweep, with the read slots of cell (0,0) checked on the way
    pulse_tick(t0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("c00_rd_k%0d", k), lookup_rd, sv[k].rd);
      if (sv[k].rd) begin
        chk($sformatf("c00_lx_k%0d", k), lookup_x, sv[k].x);
        chk($sformatf("c00_ly_k%0d", k), lookup_y, sv[k].y);
      end
    end
    wait_done(300, ok, sd_at);
    chk("s1_done_seen", ok, 1);
    @(negedge clk);
    chk("s1_nwrites", wq.size(), 12);
    for (int i = 0; i < wq.size() && i < 12; i++) begin
      chk($sformatf("s1_x%0d", i), wq[i].x, i % 4);
      chk($sformatf("s1_y%0d", i), wq[i].y, i / 4);
      chk($sformatf("s1_gap%0d", i), wq[i].cyc - (i == 0 ? t0 : wq[i-1].cyc), 11);
      chk($sformatf("s1_surr%0d", i), wq[i].surr, exp_surr(i % 4, i / 4));
      chk($sformatf("s1_csig%0d", i), wq[i].cs, 4 * (i / 4) + i % 4);
      chk($sformatf("s1_csug%0d", i), wq[i].cu, (i % 4) == (i / 4));
    end
    if (wq.size() == 12) begin
      chk("c11_surr", wq[5].surr, 32'h0489A621);
      chk("c11_csig", wq[5].cs, 5);
      chk("c11_csug", wq[5].cu, 1);
      chk("c00_surr", wq[0].surr, 32'h00045100);
      chk("c00_csug", wq[0].cu, 1);
      chk("s1_done_cyc", sd_at, wq[11].cyc + 1);
    end
    chk("s1_busy_after", busy, 0);
    chk("s1_done_count", sdcount, 1);
    chk("s1_overrun", overrun, 0);

    // pause during READ of (2,0)
    wq.delete();
    pulse_tick(t0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (busy && !write_flag && write_x == 2 && write_y == 0) ok = 1;
      else @(negedge clk);
    end
    chk("p_reach20", ok, 1);
    pause = 1;
    wait_write(50, ok);
    chk("p_w20_seen", ok, 1);
    chk("p_w20_x", write_x, 2);
    chk("p_w20_y", write_y, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(write_flag) + int'(lookup_rd) + int'(sweep_done);
    end
    chk("p_strobes", n, 0);
    chk("p_busy", busy, 1);
    pause = 0;
    wait_write(50, ok);
    chk("p_w30_seen", ok, 1);
    chk("p_w30_x", write_x, 3);
    chk("p_w30_y", write_y, 0);
    wait_done(300, ok, sd_at);
    chk("p_done_seen", ok, 1);
    @(negedge clk);
    chk("p_nwrites", wq.size(), 12);
    for (int i = 0; i < wq.size() && i < 12; i++)
      chk($sformatf("p_xy%0d", i), {wq[i].x, 1'b0, wq[i].y}, {8'(i % 4), 1'b0, 7'(i / 4)});

    // two ticks inside a sweep: overrun, exactly one queued sweep
    wq.delete();
    n = sdcount;
    pulse_tick(t0);
    repeat (20) @(negedge clk);
    pulse_tick(t0);
    chk("o_first_extra", overrun, 0);
    repeat (10) @(negedge clk);
    pulse_tick(t0);
    chk("o_second_extra", overrun, 1);
    wait_done(300, ok, sd_at);
    chk("o_done1_seen", ok, 1);
    wait_done(300, ok, sd_at2);
    chk("o_done2_seen", ok, 1);
    repeat (200) @(negedge clk);
    chk("o_done_count", sdcount - n, 2);
    chk("o_nwrites", wq.size(), 24);
    if (wq.size() > 12) chk("o_restart_gap", wq[12].cyc - sd_at, 11);
    chk("o_busy_after", busy, 0);
    chk("o_sticky", overrun, 1);

    // reset in the DRAIN of (1,2)
    wq.delete();
    pulse_tick(t0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (write_flag && write_x == 0 && write_y == 2) ok = 1;
    end
    chk("r_w02_seen", ok, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("r_pre_x", write_x, 1);
    chk("r_pre_y", write_y, 2);
    chk("r_pre_wf", write_flag, 0);
    RESET_SIM_N = 0;
    #1;
    chk_zero("r_async");
    n = wq.size();
    repeat (3) @(negedge clk);
    RESET_SIM_N = 1;
    repeat (5) @(negedge clk);
    chk("r_no_write", wq.size(), n);
    pulse_tick(t0);
    wait_write(50, ok);
    chk("r_restart_seen", ok, 1);
    chk("r_restart_x", write_x, 0);
    chk("r_restart_y", write_y, 0);
    chk("r_restart_lat", cyc - t0, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
